// File: rtl/modn_step_sequencer_if.sv
// Command channel for modn_step_sequencer.
// Carries a valid/ready handshake with direction, modulus and step count.
interface modn_step_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int STEPW = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_up;
  logic [WIDTH-1:0] cmd_mod;
  logic [STEPW-1:0] cmd_steps;

  modport master (
    output cmd_valid,
    output cmd_up,
    output cmd_mod,
    output cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_up,
    input  cmd_mod,
    input  cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/modn_step_sequencer.sv
// Command-driven mod-M up/down counter that runs a fixed number of steps.
// Optional WRAP_COUNT_EN adds a saturating wrap counter output wrap_cnt.
module modn_step_sequencer #(
  parameter int WIDTH     = 4,
  parameter int STEPW     = 8,
  parameter int N_DEFAULT = 11
) (
  input  logic             Clk,
  input  logic             reset_n,
  modn_step_sequencer_if.slave cmd,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] Count,
  output logic             wrap,
  output logic             busy,
`ifdef WRAP_COUNT_EN
  output logic [STEPW-1:0] wrap_cnt,
`endif
  output logic             done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] m_new;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] nxt;
  logic             nwrap;
  logic [STEPW-1:0] steps;
  logic             up;

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);

  // Moduli below 2 would make the counter degenerate.
  assign m_new = (cmd.cmd_mod < WIDTH'(2)) ? WIDTH'(2)
                                           : cmd.cmd_mod;
  assign last  = m - WIDTH'(1);

  always_comb begin
    nwrap = 1'b0;
    nxt   = Count;
    if (up) begin
      nwrap = (Count == last);
      nxt   = nwrap ? '0 : Count + WIDTH'(1);
    end else begin
      nwrap = (Count == '0);
      nxt   = nwrap ? last : Count - WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      Count <= '0;
      m     <= WIDTH'(N_DEFAULT);
      steps <= '0;
      up    <= 1'b1;
      wrap  <= 1'b0;
      done  <= 1'b0;
`ifdef WRAP_COUNT_EN
      wrap_cnt <= '0;
`endif
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            up    <= cmd.cmd_up;
            steps <= cmd.cmd_steps;
            m     <= m_new;
            if (Count >= m_new)
              Count <= '0;
            if (cmd.cmd_steps == '0)
              done <= 1'b1;
            else
              state <= RUN;
`ifdef WRAP_COUNT_EN
            wrap_cnt <= '0;
`endif
          end
        end
        RUN: begin
          unique case (1'b1)
            abort: begin
              state <= IDLE;
              steps <= '0;
            end
            (!abort && hold): begin
            end
            (!abort && !hold): begin
              Count <= nxt;
              wrap  <= nwrap;
              steps <= steps - STEPW'(1);
`ifdef WRAP_COUNT_EN
              if (nwrap && wrap_cnt != '1)
                wrap_cnt <= wrap_cnt + STEPW'(1);
`endif
              if (steps == STEPW'(1)) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
